// File: rtl/gtx_mmcm_reset_ctrl.sv
// ============================================================================
// gtx_mmcm_reset_ctrl : GTX MMCM reset sequencer with lock qualification/retry
// Revision: 1.0
// ============================================================================
`default_nettype none

module gtx_mmcm_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 128,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRY           = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       mmcm_lock,
  output logic       mmcm_reset,
  output logic       clk_ready,
  output logic       lock_lost,
  output logic       lock_fail,
  output logic [3:0] retry_cnt
);

  localparam int C_MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int C_MAX_CYC = (C_MAX_AB > LOCK_STABLE_CYCLES) ? C_MAX_AB : LOCK_STABLE_CYCLES;
  localparam int C_CNT_W   = $clog2(C_MAX_CYC);

  localparam logic [C_CNT_W-1:0] C_RST_LAST     = C_CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_TIMEOUT_LAST = C_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_STABLE_LAST  = C_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]         C_MAX_RETRY    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_READY      = 3'd3,
    ST_FAIL       = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_lock_meta;
  logic                 r_lock_s;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 w_cnt_clr;
  logic                 w_cnt_run;
  logic [3:0]           w_retry_nxt;
  logic [3:0]           w_retry_inc;
  logic                 w_lost_nxt;

  assign w_retry_inc = (retry_cnt == C_MAX_RETRY) ? retry_cnt : retry_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = retry_cnt;
    w_lost_nxt  = 1'b0;
    if (restart) begin
      w_state_nxt = ST_ASSERT_RST;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_ASSERT_RST: if (r_cnt == C_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == C_TIMEOUT_LAST) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == C_MAX_RETRY) ? ST_FAIL : ST_ASSERT_RST;
          end
        end
        ST_STABLE: begin
          if (!r_lock_s)                   w_state_nxt = ST_WAIT_LOCK;
          else if (r_cnt == C_STABLE_LAST) w_state_nxt = ST_READY;
        end
        ST_READY: begin
          if (!r_lock_s) begin
            w_state_nxt = ST_ASSERT_RST;
            w_lost_nxt  = 1'b1;
            w_retry_nxt = 4'd0;
          end
        end
        ST_FAIL: w_state_nxt = ST_FAIL;
        default: w_state_nxt = ST_ASSERT_RST;
      endcase
    end
  end

  // A restart inside ASSERT_RST keeps the state but must still restart the pulse count.
  assign w_cnt_clr = restart || (w_state_nxt != r_state);
  assign w_cnt_run = (r_state == ST_ASSERT_RST) || (r_state == ST_WAIT_LOCK) ||
                     (r_state == ST_STABLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= ST_ASSERT_RST;
      r_cnt       <= '0;
      retry_cnt   <= 4'd0;
      mmcm_reset  <= 1'b1;
      clk_ready   <= 1'b0;
      lock_lost   <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      r_lock_meta <= mmcm_lock;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_state_nxt;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_run) r_cnt <= r_cnt + 1'b1;
      retry_cnt   <= w_retry_nxt;
      mmcm_reset  <= (w_state_nxt == ST_ASSERT_RST) || (w_state_nxt == ST_FAIL);
      clk_ready   <= (w_state_nxt == ST_READY);
      lock_lost   <= w_lost_nxt;
      lock_fail   <= (w_state_nxt == ST_FAIL);
    end
  end

endmodule

`default_nettype wire

// File: doc/gtx_mmcm_reset_ctrl.md
# gtx_mmcm_reset_ctrl

Sequencer that drives the GTX clock module's MMCM reset and qualifies its lock output. It holds the MMCM in reset for a fixed pulse, waits for lock with a timeout, and requires lock to stay stable before declaring user clocks ready. It re-resets the MMCM on timeout or loss of lock, and latches a failure after a bounded number of retries. It runs on the free-running reference-side system clock, never on an MMCM output.

## Interface
- RST_PULSE_CYCLES, 128: cycles `mmcm_reset` is held high per attempt (≥2)
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before retry (≥2)
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock cycles required before ready (≥2)
- MAX_RETRY, 4: timed-out attempts before FAIL (1..15)

Ports:
- clk  in  1  free-running system clock; sole clock
- reset_n  in  1  synchronous, active-low reset
- restart  in  1  single-cycle request to restart the sequence from ASSERT_RST
- mmcm_lock  in  1  raw MMCM LOCKED; asynchronous to clk
- mmcm_reset  out  1  MMCM RST, active high, registered
- clk_ready  out  1  MMCM outputs qualified, registered
- lock_lost  out  1  one-cycle pulse when lock drops in READY
- lock_fail  out  1  sticky; retries exhausted
- retry_cnt  out  4  timed-out attempts in the current sequence

## Operation
- `mmcm_lock` passes through a 2-flop synchronizer (`lock_s`); the FSM uses only `lock_s`.
- One shared counter `cnt` is wide enough for the largest parameter. It clears on every state change.
- States:
  - **ASSERT_RST**
    - `mmcm_reset`=1.
    - When `cnt`==RST_PULSE_CYCLES-1 → WAIT_LOCK.
  - **WAIT_LOCK**
    - `mmcm_reset`=0.
    - If `lock_s`=1 → STABLE.
    - Else if `cnt`==LOCK_TIMEOUT_CYCLES-1, `retry_cnt` increments. If the new value equals MAX_RETRY → FAIL, else → ASSERT_RST.
  - **STABLE**
    - If `lock_s`=0 → WAIT_LOCK, with the timeout restarted and no retry increment.
    - Else if `cnt`==LOCK_STABLE_CYCLES-1 → READY.
  - **READY**
    - `clk_ready`=1.
    - If `lock_s`=0 → ASSERT_RST, `lock_lost` pulses, `retry_cnt` clears.
  - **FAIL**
    - `mmcm_reset`=1 and `lock_fail`=1, held until `restart`.
- `restart`=1 in any state → ASSERT_RST.
  - It clears `retry_cnt`, `lock_fail` and `clk_ready`.
  - It has priority over every other transition in the same cycle, including a timeout or a lock drop.
  - `lock_lost` is not pulsed when the exit from READY is caused by `restart`.
- In ASSERT_RST and WAIT_LOCK, `lock_s` from a previous attempt is ignored while `mmcm_reset`=1. A `lock_s`=1 seen in WAIT_LOCK is accepted and then qualified by STABLE.
- `retry_cnt` saturates at MAX_RETRY. It is held in FAIL.

## Timing
- Reset (`reset_n`=0 at an edge):
  - State ASSERT_RST, `cnt`=0, sync flops=0.
  - `mmcm_reset`=1, `clk_ready`=0, `lock_lost`=0, `lock_fail`=0, `retry_cnt`=0.
- Reset takes effect on the same edge and overrides `restart`.
- All outputs are registered and decoded from next-state, so each output changes on the same edge as the state change.
- `mmcm_reset` stays high for exactly RST_PULSE_CYCLES edges after the last reset edge or after ASSERT_RST entry.
- Raw `mmcm_lock` rise to `clk_ready`=1:
  - 2 edges of synchronizer
  - +1 edge WAIT_LOCK→STABLE
  - +LOCK_STABLE_CYCLES edges
- Raw `mmcm_lock` fall in READY to `clk_ready`=0, `lock_lost`=1 and `mmcm_reset`=1: 3 edges (2 sync + 1). `lock_lost` is high for exactly one cycle.
- WAIT_LOCK timeout fires LOCK_TIMEOUT_CYCLES edges after WAIT_LOCK entry.
- A `lock_s` drop on the final STABLE count cycle → WAIT_LOCK, not READY.
- `restart` asserted mid-pulse in ASSERT_RST restarts the pulse count from 0.

## Test plan
Parameters for all scenarios: RST_PULSE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=16, MAX_RETRY=3.

1. **Nominal bring-up.** Release `reset_n`; raise `mmcm_lock` 5 cycles after `mmcm_reset` falls.
   - `mmcm_reset` is high 8 cycles.
   - `clk_ready` rises 19 edges after `mmcm_lock`.
   - `retry_cnt`=0, `lock_fail`=0.
2. **No lock.** Hold `mmcm_lock`=0.
   - 3 cycles of (8-cycle reset pulse, 32-cycle wait).
   - `retry_cnt` steps 1, 2, 3.
   - `lock_fail`=1 and `mmcm_reset`=1 from the third timeout onward.
   - A `restart` pulse then clears `lock_fail` and `retry_cnt` and starts a new 8-cycle pulse.
3. **Glitchy lock.** Raise `mmcm_lock` for 10 cycles, drop for 2, then raise permanently.
   - No `clk_ready` during the glitch.
   - `retry_cnt` stays 0.
   - `clk_ready` rises 19 edges after the final rise.
4. **Loss of lock in READY.** Drop `mmcm_lock` once `clk_ready`=1.
   - 3 edges later: `lock_lost` is a one-cycle pulse, `clk_ready`=0, `mmcm_reset`=1 for 8 cycles.
   - Re-raising lock reaches READY again.
5. **Priority.** Assert `restart` on the same cycle as a WAIT_LOCK timeout (`cnt`=31).
   - → ASSERT_RST with `retry_cnt`=0, not incremented.
   - Separately, `reset_n`=0 together with `restart` gives all reset values.
